// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the register-file write port and
// the decode pending-write query.
interface regfile_wb_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_sel;
    logic [DW-1:0] a_dat;
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_sel;
    logic [DW-1:0] b_dat;
    logic          rf_WEN;
    logic [AW-1:0] rf_wsel;
    logic [DW-1:0] rf_wdat;
    logic [AW-1:0] q_sel;
    logic          q_pend;

    modport master (
        output a_valid, a_sel, a_dat, b_valid, b_sel, b_dat, q_sel,
        input  a_ready, b_ready, rf_WEN, rf_wsel, rf_wdat, q_pend
    );

    modport slave (
        input  a_valid, a_sel, a_dat, b_valid, b_sel, b_dat, q_sel,
        output a_ready, b_ready, rf_WEN, rf_wsel, rf_wdat, q_pend
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two one-entry writeback buffers (A=ALU, B=mem) drained round-robin into a
// registered register-file write port, plus a pending-write query for decode.
module regfile_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic               CLK,
    input  logic               nRST,
    regfile_wb_arbiter_if.slave wb
);
    typedef logic [DW-1:0] word_t;
    typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} last_t;

    // Index 0 is requester A, index 1 is requester B.
    logic          in_valid [2];
    logic [AW-1:0] in_sel   [2];
    word_t         in_dat   [2];
    logic          ready    [2];
    logic          grant    [2];
    logic          buf_v    [2];
    logic [AW-1:0] buf_sel  [2];
    word_t         buf_dat  [2];

    last_t         last_reg, last_next;
    logic          wen_reg;
    logic [AW-1:0] wsel_reg;
    word_t         wdat_reg;
    logic [AW-1:0] gnt_sel;
    word_t         gnt_dat;
    logic          gnt_any;

    assign in_valid[0] = wb.a_valid;
    assign in_sel[0]   = wb.a_sel;
    assign in_dat[0]   = wb.a_dat;
    assign in_valid[1] = wb.b_valid;
    assign in_sel[1]   = wb.b_sel;
    assign in_dat[1]   = wb.b_dat;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            // A granted buffer is emptied this edge, so it may take a new entry.
            assign ready[gi] = !buf_v[gi] || grant[gi];

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    buf_v[gi]   <= 1'b0;
                    buf_sel[gi] <= '0;
                    buf_dat[gi] <= '0;
                end else if (in_valid[gi] && ready[gi]) begin
                    buf_v[gi]   <= 1'b1;
                    buf_sel[gi] <= in_sel[gi];
                    buf_dat[gi] <= in_dat[gi];
                end else if (grant[gi]) begin
                    buf_v[gi]   <= 1'b0;
                end
            end
        end
    endgenerate

    assign wb.a_ready = ready[0];
    assign wb.b_ready = ready[1];

    // Round-robin: on contention the requester not served last wins.
    always_comb begin
        grant[0]  = 1'b0;
        grant[1]  = 1'b0;
        last_next = last_reg;
        gnt_sel   = buf_sel[1];
        gnt_dat   = buf_dat[1];
        if (buf_v[0] && (!buf_v[1] || last_reg == LAST_B)) begin
            grant[0]  = 1'b1;
            last_next = LAST_A;
            gnt_sel   = buf_sel[0];
            gnt_dat   = buf_dat[0];
        end else if (buf_v[1]) begin
            grant[1]  = 1'b1;
            last_next = LAST_B;
        end
    end

    assign gnt_any = grant[0] || grant[1];

    // Writes to register 0 are consumed from the buffer but never enabled.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_reg <= LAST_B;
            wen_reg  <= 1'b0;
            wsel_reg <= '0;
            wdat_reg <= '0;
        end else begin
            last_reg <= last_next;
            if (gnt_any) begin
                wen_reg  <= (gnt_sel != '0);
                wsel_reg <= gnt_sel;
                wdat_reg <= gnt_dat;
            end else begin
                wen_reg  <= 1'b0;
            end
        end
    end

    assign wb.rf_WEN  = wen_reg;
    assign wb.rf_wsel = wsel_reg;
    assign wb.rf_wdat = wdat_reg;

    assign wb.q_pend = (wb.q_sel != '0) &&
                       ((buf_v[0] && (buf_sel[0] == wb.q_sel)) ||
                        (buf_v[1] && (buf_sel[1] == wb.q_sel)) ||
                        (wen_reg  && (wsel_reg   == wb.q_sel)));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected register-file writes are
// queued by the stimulus and compared by an independent monitor.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic CLK;
    logic nRST;
    int   errors = 0;
    int   checks = 0;
    logic [AW+DW-1:0] exp_q[$];

    regfile_wb_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .wb   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: act=0x%0h req=0x%0h at %0t", name, act, req, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #3 nRST = 1'b1;
        tick();
    endtask

    // Monitor: every enabled write must match the head of the expected queue.
    always @(negedge CLK) begin
        if (nRST === 1'b1 && bus.rf_WEN === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: act sel=%0d dat=0x%0h req=no write", bus.rf_wsel, bus.rf_wdat);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                chk("mon_wsel", 32'(bus.rf_wsel), 32'(e[AW+DW-1:DW]));
                chk("mon_wdat", bus.rf_wdat, e[DW-1:0]);
            end
        end
    end

    initial begin
        int ka, kb;
        logic sa, sb;
        nRST = 1'b0;
        bus.a_valid = 1'b0; bus.a_sel = '0; bus.a_dat = '0;
        bus.b_valid = 1'b0; bus.b_sel = '0; bus.b_dat = '0;
        bus.q_sel = '0;
        #2;
        chk("rst_a_ready", 32'(bus.a_ready), 1);
        chk("rst_b_ready", 32'(bus.b_ready), 1);
        chk("rst_wen",     32'(bus.rf_WEN),  0);
        chk("rst_qpend",   32'(bus.q_pend),  0);
        do_reset();

        // 1: single A write, latency and pending window
        bus.a_valid = 1'b1; bus.a_sel = 5'd5; bus.a_dat = 32'hDEADBEEF; bus.q_sel = 5'd5;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        @(negedge CLK);
        chk("t1_a_ready", 32'(bus.a_ready), 1);
        chk("t1_qpend_pre", 32'(bus.q_pend), 0);
        tick();
        bus.a_valid = 1'b0;
        @(negedge CLK);
        chk("t1_wen_t1", 32'(bus.rf_WEN), 0);
        chk("t1_qpend_t1", 32'(bus.q_pend), 1);
        tick();
        @(negedge CLK);
        chk("t1_wen_t2", 32'(bus.rf_WEN), 1);
        chk("t1_qpend_t2", 32'(bus.q_pend), 1);
        tick();
        @(negedge CLK);
        chk("t1_wen_t3", 32'(bus.rf_WEN), 0);
        chk("t1_qpend_t3", 32'(bus.q_pend), 0);
        tick();

        // 2: simultaneous accept after reset, A first since last=B
        do_reset();
        bus.a_valid = 1'b1; bus.a_sel = 5'd3; bus.a_dat = 32'h11;
        bus.b_valid = 1'b1; bus.b_sel = 5'd4; bus.b_dat = 32'h22;
        exp_q.push_back({5'd3, 32'h11});
        exp_q.push_back({5'd4, 32'h22});
        @(negedge CLK);
        chk("t2_a_ready_t0", 32'(bus.a_ready), 1);
        chk("t2_b_ready_t0", 32'(bus.b_ready), 1);
        tick();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        @(negedge CLK);
        chk("t2_a_ready_t1", 32'(bus.a_ready), 1);
        chk("t2_b_ready_t1", 32'(bus.b_ready), 0);
        tick();
        @(negedge CLK);
        chk("t2_wen_t2", 32'(bus.rf_WEN), 1);
        chk("t2_b_ready_t2", 32'(bus.b_ready), 1);
        tick();
        @(negedge CLK);
        chk("t2_wen_t3", 32'(bus.rf_WEN), 1);
        tick();
        @(negedge CLK);
        chk("t2_wen_t4", 32'(bus.rf_WEN), 0);
        tick();

        // 3: continuous contention for 8 cycles; expected order A0 B0 A1 B1 ... A4
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({5'(10 + k), 32'hA000_0000 + 32'(k)});
            exp_q.push_back({5'(20 + k), 32'hB000_0000 + 32'(k)});
        end
        exp_q.push_back({5'd14, 32'hA000_0004});
        ka = 0; kb = 0;
        for (int c = 0; c < 12; c++) begin
            bus.a_valid = (c < 8); bus.a_sel = 5'(10 + ka); bus.a_dat = 32'hA000_0000 + 32'(ka);
            bus.b_valid = (c < 8); bus.b_sel = 5'(20 + kb); bus.b_dat = 32'hB000_0000 + 32'(kb);
            @(negedge CLK);
            if (c < 8) begin
                chk($sformatf("t3_a_ready_c%0d", c), 32'(bus.a_ready), 32'((c == 0) || (c % 2 == 1)));
                chk($sformatf("t3_b_ready_c%0d", c), 32'(bus.b_ready), 32'((c == 0) || (c % 2 == 0)));
            end
            if (c >= 2) chk($sformatf("t3_wen_c%0d", c), 32'(bus.rf_WEN), 32'(c <= 10));
            sa = bus.a_valid && bus.a_ready;
            sb = bus.b_valid && bus.b_ready;
            tick();
            if (sa) ka++;
            if (sb) kb++;
        end
        chk("t3_a_accepts", 32'(ka), 5);
        chk("t3_b_accepts", 32'(kb), 4);

        // 4: write to register 0 is consumed silently
        bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.q_sel = 5'd0;
        bus.b_valid = 1'b1; bus.b_sel = 5'd0; bus.b_dat = 32'hFFFFFFFF;
        @(negedge CLK);
        chk("t4_b_ready", 32'(bus.b_ready), 1);
        chk("t4_qpend_t0", 32'(bus.q_pend), 0);
        tick();
        bus.b_valid = 1'b0;
        @(negedge CLK);
        chk("t4_qpend_t1", 32'(bus.q_pend), 0);
        tick();
        @(negedge CLK);
        chk("t4_wen_t2", 32'(bus.rf_WEN), 0);
        chk("t4_qpend_t2", 32'(bus.q_pend), 0);
        tick();

        // 5: reset with both buffers full discards everything
        bus.a_valid = 1'b1; bus.a_sel = 5'd7; bus.a_dat = 32'h77;
        bus.b_valid = 1'b1; bus.b_sel = 5'd8; bus.b_dat = 32'h88;
        bus.q_sel = 5'd7;
        tick();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        #1;
        chk("t5_qpend_full", 32'(bus.q_pend), 1);
        nRST = 1'b0;
        #1;
        chk("t5_rst_wen", 32'(bus.rf_WEN), 0);
        chk("t5_rst_qpend7", 32'(bus.q_pend), 0);
        chk("t5_rst_a_ready", 32'(bus.a_ready), 1);
        chk("t5_rst_b_ready", 32'(bus.b_ready), 1);
        bus.q_sel = 5'd8;
        #1;
        chk("t5_rst_qpend8", 32'(bus.q_pend), 0);
        repeat (2) @(posedge CLK);
        #3 nRST = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            chk($sformatf("t5_post_wen_c%0d", c), 32'(bus.rf_WEN), 0);
            chk($sformatf("t5_post_ready_c%0d", c), 32'({bus.a_ready, bus.b_ready}), 32'b11);
        end
        tick();

        // 6: A-only stream sel 1..6; last=B after reset, so A is never blocked
        for (int s = 1; s <= 6; s++) exp_q.push_back({5'(s), 32'h600 + 32'(s)});
        for (int c = 0; c < 9; c++) begin
            bus.a_valid = (c < 6); bus.a_sel = 5'(c + 1); bus.a_dat = 32'h600 + 32'(c + 1);
            @(negedge CLK);
            if (c < 6) chk($sformatf("t6_a_ready_c%0d", c), 32'(bus.a_ready), 1);
            if (c >= 2) chk($sformatf("t6_wen_c%0d", c), 32'(bus.rf_WEN), 32'(c <= 7));
            tick();
        end
        bus.a_valid = 1'b0;

        chk("final_queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register file write port (WEN/wsel/wdat) between two writeback requesters: A (ALU pipe) and B (memory/multicycle unit).
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter drains the buffers into a registered write port that drives the register file directly.
- A combinational pending-write query lets decode stall on registers whose write has not yet landed.

Parameters:
- DW, 32, data width (word_t).
- AW, 5, register select width (32 registers).

Ports:
- CLK  in  1  clock, all state on rising edge.
- nRST  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A has a write.
- a_ready  out  1  A buffer can accept this cycle.
- a_sel  in  AW  A destination register.
- a_dat  in  DW  A write data.
- b_valid  in  1  requester B has a write.
- b_ready  out  1  B buffer can accept this cycle.
- b_sel  in  AW  B destination register.
- b_dat  in  DW  B write data.
- rf_WEN  out  1  register file write enable (registered).
- rf_wsel  out  AW  register file write select (registered).
- rf_wdat  out  DW  register file write data (registered).
- q_sel  in  AW  register being queried by decode.
- q_pend  out  1  write to q_sel is outstanding.

Behaviour:
- Reset (async, nRST=0) clears bufA_v, bufB_v, buffer sel/dat, rf_WEN, rf_wsel and rf_wdat to 0; sets last=B.
- Outputs while in reset: a_ready=1, b_ready=1, q_pend=0. Reset mid-operation discards all buffered and in-flight writes.
- Handshake:
  - A transfer occurs when x_valid & x_ready at a rising edge; buffer x is loaded with sel/dat and bufX_v=1.
  - x_ready = !bufX_v | grantX (combinational). A buffer may be drained and refilled in the same cycle.
  - Requester data is ignored when x_valid=0.
- Arbitration (combinational, each cycle):
  - Only bufA_v set: grantA. Only bufB_v set: grantB.
  - Both set: grant the one not equal to last.
  - last updates to the granted requester on any grant; it holds when there is no grant.
  - Exactly one grant per cycle, at most.
- Write port (registered):
  - On grant, the next edge sets rf_wsel/rf_wdat from the granted buffer and clears its bufX_v unless it is refilled the same edge.
  - rf_WEN = 1 only if the granted sel != 0. A write to register 0 is consumed but suppressed.
  - No grant: rf_WEN=0; rf_wsel/rf_wdat hold their previous values.
- Latency:
  - Accept at edge t.
  - Grant during cycle t+1 if uncontested.
  - rf_WEN high during cycle t+2; the register file commits at the end of t+2.
  - Under continuous contention, each requester gets every other slot, so each sustains 1 write per 2 cycles.
- Same-register conflict:
  - Writes are committed in grant order; the later grant wins.
  - Program order between A and B is the requesters' responsibility.
- q_pend = (q_sel != 0) & ((bufA_v & bufA_sel==q_sel) | (bufB_v & bufB_sel==q_sel) | (rf_WEN & rf_wsel==q_sel)).
  - Purely combinational.
  - Does not include the current-cycle a/b inputs.
- No storage beyond two buffers and the output register. No FIFO overflow is possible; backpressure is via x_ready.

Test Plan:
1. Reset, then A writes sel=5 dat=0xDEADBEEF alone -> a_ready=1 at accept; rf_WEN=1, rf_wsel=5, rf_wdat=0xDEADBEEF exactly two cycles after accept; q_pend(5)=1 from the cycle after accept through the WEN cycle, then 0.
2. A (sel=3, 0x11) and B (sel=4, 0x22) accepted same edge after reset -> A written first (last=B at reset), B one cycle later; b_ready=0 for one cycle.
3. A and B both held valid for 8 cycles with incrementing data -> rf_WEN continuously 1; writes alternate A,B,A,B; each ready pulses every other cycle; no data lost or duplicated.
4. B writes sel=0 dat=0xFFFFFFFF -> accepted (b_ready=1); rf_WEN stays 0 in the slot; q_sel=0 gives q_pend=0 throughout.
5. Both buffers full, nRST asserted mid-cycle -> rf_WEN=0 and q_pend=0 immediately; after release, no stale write appears and both readies are 1.
6. A single-source stream, a_valid every cycle with sel=1..6 -> a_ready stays 1; rf_WEN is 1 for six consecutive cycles with sel 1..6 in order.
